// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that shares a 4-digit 7-segment display between NREQ requesters.
// The owner's 16-bit value is hex-decoded into active-low segment patterns; seg1 is the LS nibble.
module seg_display_arbiter #(
    parameter int NREQ        = 3,
    parameter int HOLD_CYCLES = 1000,
    parameter int LZ_BLANK    = 0
) (
    input  logic                 clk10,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   val,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic [6:0]           seg1,
    output logic [6:0]           seg2,
    output logic [6:0]           seg3,
    output logic [6:0]           seg4
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [6:0]        seg1_q, seg1_d, seg2_q, seg2_d, seg3_q, seg3_d, seg4_q, seg4_d;

    logic              own_req_s;
    logic [15:0]       own_val_s;
    logic [NREQ-1:0]   others_s;
    logic [IW-1:0]     grant_idx_s;
    logic              do_grant_s;
    logic              blank4_s, blank3_s, blank2_s;

    // First set bit of r scanning circularly upward from ptr.
    function automatic logic [IW-1:0] pick_f(input logic [NREQ-1:0] r, input logic [IW-1:0] ptr);
        logic          found;
        logic [IW-1:0] res;
        int            idx;
        found = 1'b0;
        res   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found && r[IW'(idx)]) begin
                found = 1'b1;
                res   = IW'(idx);
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    function automatic logic [6:0] hex_f(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Owner request and value, selected through the one-hot grant.
    always_comb begin
        own_val_s = 16'h0000;
        for (int i = 0; i < NREQ; i++) begin
            own_val_s = own_val_s | (val[16*i +: 16] & {16{gnt_q[i]}});
        end
        own_req_s   = |(req & gnt_q);
        others_s    = req & ~gnt_q;
        grant_idx_s = (state_q == ST_IDLE) ? pick_f(req, rr_ptr_q) : pick_f(others_s, rr_ptr_q);
        do_grant_s  = ((state_q == ST_IDLE) && (|req)) || ((state_q == ST_OWN) && (|others_s));
    end

    // Next-state, grant, hold counter and shadow value.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        shadow_d   = shadow_q;

        case (state_q)
            ST_IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_OWN;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            ST_OWN: begin
                if (!(|others_s) && !own_req_s) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_OWN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        // A new grant (from idle or as a handover) overrides the per-state choice.
        if (do_grant_s) begin
            state_d              = ST_HOLD;
            gnt_d                = '0;
            gnt_d[grant_idx_s]   = 1'b1;
            busy_d               = 1'b1;
            hold_cnt_d           = HW'(HOLD_CYCLES - 1);
            rr_ptr_d             = (grant_idx_s == IW'(NREQ - 1)) ? '0 : grant_idx_s + IW'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        if ((state_q != ST_IDLE) && own_req_s) begin
            shadow_d = own_val_s;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Segment patterns: dashes whenever idle, otherwise decoded shadow with optional blanking.
    always_comb begin
        blank4_s = (LZ_BLANK != 0) && (shadow_q[15:12] == 4'h0);
        blank3_s = blank4_s && (shadow_q[11:8] == 4'h0);
        blank2_s = blank3_s && (shadow_q[7:4] == 4'h0);
        if (state_d == ST_IDLE) begin
            seg1_d = SEG_DASH;
            seg2_d = SEG_DASH;
            seg3_d = SEG_DASH;
            seg4_d = SEG_DASH;
        end else begin
            seg1_d = hex_f(shadow_q[3:0]);
            seg2_d = blank2_s ? SEG_BLANK : hex_f(shadow_q[7:4]);
            seg3_d = blank3_s ? SEG_BLANK : hex_f(shadow_q[11:8]);
            seg4_d = blank4_s ? SEG_BLANK : hex_f(shadow_q[15:12]);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk10) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            shadow_q   <= 16'h0000;
            seg1_q     <= SEG_DASH;
            seg2_q     <= SEG_DASH;
            seg3_q     <= SEG_DASH;
            seg4_q     <= SEG_DASH;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            shadow_q   <= shadow_d;
            seg1_q     <= seg1_d;
            seg2_q     <= seg2_d;
            seg3_q     <= seg3_d;
            seg4_q     <= seg4_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign seg1 = seg1_q;
    assign seg2 = seg2_q;
    assign seg3 = seg3_q;
    assign seg4 = seg4_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized bench for seg_display_arbiter: two instances (plain and leading-zero blanking)
// compared every cycle against an ownership-age reference model.
module tb_seg_display_arbiter;

    localparam int NREQ = 3;
    localparam int HOLD = 4;

    logic                 clk10 = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   val;

    logic [NREQ-1:0]      gnt_a, gnt_b;
    logic                 busy_a, busy_b;
    logic [6:0]           sa1, sa2, sa3, sa4, sb1, sb2, sb3, sb4;

    int err_cnt = 0;
    int chk_cnt = 0;

    int          m_owner = -1;
    int          m_age   = 0;
    int          m_rr    = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic [6:0]  m_seg [2][4];
    logic [6:0]  hex_tab [16];

    seg_display_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .LZ_BLANK(0)) dut (
        .clk10(clk10), .rst(rst), .req(req), .val(val), .gnt(gnt_a), .busy(busy_a),
        .seg1(sa1), .seg2(sa2), .seg3(sa3), .seg4(sa4));

    seg_display_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .LZ_BLANK(1)) dut_lz (
        .clk10(clk10), .rst(rst), .req(req), .val(val), .gnt(gnt_b), .busy(busy_b),
        .seg1(sb1), .seg2(sb2), .seg3(sb3), .seg4(sb4));

    always #5 clk10 = ~clk10;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int from);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(from + i) % NREQ]) return (from + i) % NREQ;
        end
        return -1;
    endfunction

    // Digit k is blank when blanking is on and every nibble from k upward is zero.
    function automatic logic [6:0] digit(input logic [15:0] v, input int k, input bit lz);
        if (lz && k > 0 && (v >> (4 * k)) == 16'h0000) return 7'h7F;
        return hex_tab[(v >> (4 * k)) & 16'h000F];
    endfunction

    task automatic model_edge();
        logic [15:0]     sh_prev;
        logic [NREQ-1:0] others;
        sh_prev = m_shadow;
        if (rst) begin
            m_owner  = -1;
            m_rr     = 0;
            m_shadow = 16'h0000;
        end else if (m_owner < 0) begin
            if (|req) begin
                m_owner = pick(req, m_rr);
                m_rr    = (m_owner + 1) % NREQ;
                m_age   = 0;
            end
        end else begin
            m_age++;
            if (req[m_owner]) m_shadow = val[16*m_owner +: 16];
            if (m_age > HOLD) begin
                others = req;
                others[m_owner] = 1'b0;
                if (|others) begin
                    m_owner = pick(others, m_rr);
                    m_rr    = (m_owner + 1) % NREQ;
                    m_age   = 0;
                end else if (!req[m_owner]) begin
                    m_owner = -1;
                end
            end
        end
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 4; k++) begin
                m_seg[u][k] = (m_owner < 0) ? 7'h3F : digit(sh_prev, k, u == 1);
            end
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] exp_gnt;
        @(posedge clk10);
        model_edge();
        @(negedge clk10);
        exp_gnt = '0;
        if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
        check_val("gnt", 32'(gnt_a), 32'(exp_gnt));
        check_val("busy", 32'(busy_a), 32'(m_owner >= 0));
        check_val("seg1", 32'(sa1), 32'(m_seg[0][0]));
        check_val("seg2", 32'(sa2), 32'(m_seg[0][1]));
        check_val("seg3", 32'(sa3), 32'(m_seg[0][2]));
        check_val("seg4", 32'(sa4), 32'(m_seg[0][3]));
        check_val("lz_gnt", 32'(gnt_b), 32'(exp_gnt));
        check_val("lz_seg1", 32'(sb1), 32'(m_seg[1][0]));
        check_val("lz_seg2", 32'(sb2), 32'(m_seg[1][1]));
        check_val("lz_seg3", 32'(sb3), 32'(m_seg[1][2]));
        check_val("lz_seg4", 32'(sb4), 32'(m_seg[1][3]));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst = 1'b1;
        req = '0;
        val = '0;
        @(negedge clk10);
        steps(3);

        // Single requester, then release.
        rst = 1'b0;
        val[15:0] = 16'h10A3;
        req = 3'b001;
        steps(3);
        check_val("dir_seg4", 32'(sa4), 32'h79);
        check_val("dir_seg1", 32'(sa1), 32'h30);
        req = 3'b000;
        steps(8);

        // All requesting: rotation without idle gaps.
        val = {16'hC0DE, 16'h2B7F, 16'h0456};
        req = 3'b111;
        steps(4 * (HOLD + 1) + 2);
        req = 3'b000;
        steps(8);

        // Owner drops after one cycle while its value keeps changing.
        req = 3'b001;
        steps(2);
        req = 3'b000;
        for (int i = 0; i < 8; i++) begin
            val[15:0] = 16'($urandom);
            step();
        end

        // Leading-zero patterns.
        val[15:0] = 16'h0000;
        req = 3'b001;
        steps(4);
        check_val("lz_zero_seg4", 32'(sb4), 32'h7F);
        check_val("lz_zero_seg1", 32'(sb1), 32'h40);
        val[15:0] = 16'h0010;
        steps(3);
        check_val("lz_10_seg2", 32'(sb2), 32'h79);
        req = 3'b000;
        steps(10);

        // Reset during hold.
        req = 3'b011;
        steps(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(3);

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) req = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0)
                    val[16*i +: 16] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            end
            rst = ($urandom_range(0, 150) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
